// File: rtl/conv2d_stream_fix_pkg.sv
// Shared types and fixed-point helpers for the streaming 2-D convolution engine.
// Arithmetic widths here set the default datapath configuration.
package conv_pkg;

    localparam int CFG_DATA_W = 32;
    localparam int CFG_FRAC_W = 16;
    localparam int CFG_K      = 3;
    localparam int ACC_W      = 2 * CFG_DATA_W + $clog2(CFG_K * CFG_K);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - CFG_DATA_W + 1){1'b0}}, {(CFG_DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - CFG_DATA_W + 1){1'b1}}, {(CFG_DATA_W - 1){1'b0}}};

    // Floor-shift out the fraction bits, then clamp into the signed result range.
    function automatic logic [CFG_DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc,
                                                       input int frac);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> frac;
        if (sh > SAT_MAX) return SAT_MAX[CFG_DATA_W-1:0];
        if (sh < SAT_MIN) return SAT_MIN[CFG_DATA_W-1:0];
        return sh[CFG_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/conv2d_stream_fix_if.sv
// Pixel-in / result-out ready-valid stream bundle for the convolution engine.
interface conv2d_stream_fix_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] a;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] result;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  a, in_valid, out_ready,
        output in_ready, result, out_valid
    );

    modport master (
        output a, in_valid, out_ready,
        input  in_ready, result, out_valid
    );
endinterface

// File: rtl/conv2d_stream_fix_line_buffer.sv
// K-1 cascaded row buffers; taps are read at addr before the same-address write lands.
module conv_line_buffer #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 8,
    parameter int ROWS   = 2,
    parameter int AW     = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] taps [ROWS]
);

    logic [DATA_W-1:0] mem_q [ROWS][IMG_W];

    always_comb begin
        for (int r = 0; r < ROWS; r++) taps[r] = mem_q[r][addr];
    end

    // Row r holds the pixels from r+1 rows above the incoming one.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int x = 0; x < IMG_W; x++) mem_q[r][x] <= '0;
        end else if (we) begin
            mem_q[0][addr] <= din;
            for (int r = 1; r < ROWS; r++) mem_q[r][addr] <= mem_q[r-1][addr];
        end
    end

endmodule

// File: rtl/conv2d_stream_fix.sv
// Streaming KxK fixed-point convolution over raster pixels, one saturated result per full window.
//   state | meaning
//   IDLE  | coefficient writes accepted, waiting for start
//   RUN   | accepting pixels and streaming results
//   DONE  | single cycle after the frame's last result is taken
module conv2d_stream_fix
    import conv_pkg::*;
#(
    parameter int DATA_W = CFG_DATA_W,
    parameter int FRAC_W = CFG_FRAC_W,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = CFG_K,
    localparam int CA_W  = (K > 1) ? $clog2(K * K) : 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              coef_we_i,
    input  logic [CA_W-1:0]   coef_addr_i,
    input  logic [DATA_W-1:0] coef_data_i,
    input  logic              start_i,
    output logic              end_conv_o,
    output logic              busy_o,
    conv2d_stream_fix_if.slave strm
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam int NT = (K > 1) ? K - 1 : 1;
    localparam int PW = 2 * DATA_W;

    state_e                   state_q, state_d;
    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic                     last_in_q, last_in_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        result_q, result_d;
    logic signed [DATA_W-1:0] coef_q [K*K];
    logic signed [DATA_W-1:0] win_q [K][K];
    logic signed [DATA_W-1:0] win_d [K][K];
    logic signed [DATA_W-1:0] col_v [K];
    logic [DATA_W-1:0]        taps [NT];
    logic signed [ACC_W-1:0]  acc;
    logic signed [PW-1:0]     prod;
    logic                     pix_acc, out_acc, produce;

    conv_line_buffer #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .ROWS(NT), .AW(CW)
    ) u_lb (
        .clock(clock), .rst(rst), .we(pix_acc), .addr(col_q), .din(strm.a), .taps(taps)
    );

    // last_in_q blocks stray pixels while the final result drains.
    assign strm.in_ready  = (state_q == RUN) && !last_in_q && (strm.out_ready || !out_valid_q);
    assign strm.out_valid = out_valid_q;
    assign strm.result    = result_q;
    assign pix_acc        = strm.in_valid && strm.in_ready;
    assign out_acc        = out_valid_q && strm.out_ready;
    assign produce        = pix_acc && (int'(row_q) >= K - 1) && (int'(col_q) >= K - 1);
    assign end_conv_o     = (state_q == RUN) && last_in_q && out_acc;
    assign busy_o         = (state_q != IDLE);

    // The MAC sees the window including the pixel being accepted now.
    always_comb begin
        col_v[K-1] = strm.a;
        for (int y = 0; y < K - 1; y++) col_v[y] = taps[K-2-y];
        win_d = win_q;
        if (pix_acc) begin
            for (int y = 0; y < K; y++) begin
                for (int x = 0; x < K - 1; x++) win_d[y][x] = win_q[y][x+1];
                win_d[y][K-1] = col_v[y];
            end
        end
        acc  = '0;
        prod = '0;
        for (int y = 0; y < K; y++) begin
            for (int x = 0; x < K; x++) begin
                prod = PW'(win_d[y][x]) * PW'(coef_q[y*K+x]);
                acc  = acc + ACC_W'(prod);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        last_in_d   = last_in_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d   = RUN;
                col_d     = '0;
                row_d     = '0;
                last_in_d = 1'b0;
            end
            RUN: begin
                if (pix_acc) begin
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        if (row_q == RW'(IMG_H - 1)) begin
                            row_d     = '0;
                            last_in_d = 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (end_conv_o) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (produce) begin
            result_d    = sat_shift(acc, FRAC_W);
            out_valid_d = 1'b1;
        end else if (out_acc) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            last_in_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            win_q       <= '{default: '0};
            coef_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            last_in_q   <= last_in_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            win_q       <= win_d;
            if (state_q == IDLE && coef_we_i && int'(coef_addr_i) < K * K)
                coef_q[coef_addr_i] <= coef_data_i;
        end
    end

endmodule

// File: tb/tb_conv2d_stream_fix.sv
// Scoreboard bench for conv2d_stream_fix: 8x8 frames with identity, box and saturating inputs.
module tb_conv2d_stream_fix;

    localparam int DW   = 32;
    localparam int IW   = 8;
    localparam int IH   = 8;
    localparam int KK   = 3;
    localparam int NOUT = (IW - KK + 1) * (IH - KK + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [31:0] coef_data = '0;
    logic        start = 1'b0;
    logic        end_conv, busy;

    conv2d_stream_fix_if #(.DATA_W(DW)) sif ();

    conv2d_stream_fix #(
        .DATA_W(DW), .FRAC_W(16), .IMG_W(IW), .IMG_H(IH), .K(KK)
    ) dut (
        .clock(clk), .rst(rst), .coef_we_i(coef_we), .coef_addr_i(coef_addr),
        .coef_data_i(coef_data), .start_i(start), .end_conv_o(end_conv),
        .busy_o(busy), .strm(sif)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    bit          pend_v = 0;
    logic [3:0]  pend_addr = '0;
    logic [31:0] pend_data = '0;

    function automatic logic [31:0] pix(input int kind, input int r, input int c);
        case (kind)
            1:       return 32'h7FFF0000;
            2:       return 32'hFFFF0000;
            default: return 32'((r * IW + c) << 16);
        endcase
    endfunction

    // Closed-form expected result for window top-left (i,j) of each scenario.
    function automatic logic [31:0] exp_val(input int mode, input int i, input int j);
        int ctr;
        ctr = (i + 1) * IW + (j + 1);
        case (mode)
            1:       return 32'(ctr << 16);
            2:       return 32'((9 * ctr) << 16);
            3:       return 32'h7FFFFFFF;
            4:       return 32'hFFF70000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic load_coefs(input int kind, input bit defer_last);
        logic [31:0] v;
        for (int i = 0; i < KK * KK; i++) begin
            v = (kind == 1 || i == 4) ? 32'h00010000 : 32'h0;
            if (defer_last && i == KK * KK - 1) begin
                pend_v = 1; pend_addr = 4'(i); pend_data = v;
            end else begin
                @(negedge clk);
                coef_we = 1; coef_addr = 4'(i); coef_data = v;
            end
        end
        @(negedge clk);
        coef_we = 0;
    endtask

    task automatic run_frame(input string name, input int kind, input int mode,
                             input bit bp, input bit poke);
        int n_out, n_end;
        n_out = 0; n_end = 0;
        @(negedge clk);
        start = 1;
        if (pend_v) begin
            coef_we = 1; coef_addr = pend_addr; coef_data = pend_data; pend_v = 0;
        end
        @(negedge clk);
        start = 0; coef_we = 0;
        fork
            begin
                for (int p = 0; p < IW * IH; p++) begin
                    int r, c, w;
                    bit acc;
                    r = p / IW; c = p % IW; w = 0; acc = 0;
                    while (!acc && w < 200) begin
                        @(negedge clk);
                        sif.in_valid = 1; sif.a = pix(kind, r, c);
                        coef_we = poke && p == 30 && w == 0;
                        coef_addr = 4'd4; coef_data = 32'h7FFF0000;
                        #1 acc = sif.in_ready;
                        w++;
                    end
                    if (!acc) begin
                        n_checks++; n_fail++;
                        $display("FAIL %s pixel_timeout p=%0d in_ready=%b want 1", name, p, sif.in_ready);
                        break;
                    end
                    if (r >= KK - 1 && c >= KK - 1)
                        exp_q.push_back(exp_val(mode, r - KK + 1, c - KK + 1));
                end
                @(negedge clk);
                coef_we = 0;
                #1 n_checks++;
                if (sif.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s extra_pixel in_ready=%b want 0", name, sif.in_ready);
                end
                sif.in_valid = 0;
            end
            begin
                int mc;
                bit held_v;
                logic [31:0] held, e;
                mc = 0; held_v = 0; held = '0;
                while (n_out < NOUT && mc < 3000) begin
                    @(negedge clk);
                    mc++;
                    sif.out_ready = !(bp && mc >= 40 && mc < 45);
                    #1;
                    if (end_conv) n_end++;
                    if (sif.out_valid && !sif.out_ready) begin
                        n_checks++;
                        if (sif.in_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL %s stall_in_ready got %b want 0", name, sif.in_ready);
                        end
                        if (held_v) begin
                            n_checks++;
                            if (sif.result !== held) begin
                                n_fail++;
                                $display("FAIL %s stall_result got %h want %h", name, sif.result, held);
                            end
                        end
                        held = sif.result; held_v = 1;
                    end else begin
                        held_v = 0;
                    end
                    if (sif.out_valid && sif.out_ready) begin
                        n_out++;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL %s unexpected_output got %h want none", name, sif.result);
                        end else begin
                            e = exp_q.pop_front();
                            if (sif.result !== e) begin
                                n_fail++;
                                $display("FAIL %s result[%0d] got %h want %h", name, n_out - 1, sif.result, e);
                            end
                        end
                        n_checks++;
                        if (end_conv !== (n_out == NOUT)) begin
                            n_fail++;
                            $display("FAIL %s end_conv[%0d] got %b want %b", name, n_out - 1, end_conv, n_out == NOUT);
                        end
                    end
                end
                sif.out_ready = 1;
                n_checks++;
                if (n_out != NOUT) begin
                    n_fail++;
                    $display("FAIL %s out_count got %0d want %0d", name, n_out, NOUT);
                end
            end
        join
        n_checks++;
        if (n_end != 1) begin
            n_fail++;
            $display("FAIL %s end_pulses got %0d want 1", name, n_end);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover_expected got %0d want 0", name, exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        #1 n_checks++;
        if (busy !== 1'b1 || sif.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_state busy=%b in_ready=%b want 1 0", name, busy, sif.in_ready);
        end
        @(negedge clk);
        #1 n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_state busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        #1 n_checks++;
        if (sif.out_valid !== 1'b0 || busy !== 1'b0 || sif.in_ready !== 1'b0 ||
            end_conv !== 1'b0 || sif.result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state ov=%b busy=%b ir=%b ec=%b res=%h want 0 0 0 0 0",
                     sif.out_valid, busy, sif.in_ready, end_conv, sif.result);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_identity;
        load_coefs(0, 0);
        run_frame("identity", 0, 1, 0, 0);
    endtask

    task automatic test_box;
        load_coefs(1, 1);
        run_frame("box", 0, 2, 0, 0);
    endtask

    task automatic test_saturation;
        run_frame("sat_pos", 1, 3, 0, 0);
        run_frame("sat_neg", 2, 4, 0, 0);
    endtask

    task automatic test_backpressure;
        run_frame("backpressure", 0, 2, 1, 0);
    endtask

    task automatic test_reset_mid_frame;
        int p, guard;
        load_coefs(0, 0);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        sif.out_ready = 1;
        p = 0; guard = 0;
        while (p < 20 && guard < 500) begin
            @(negedge clk);
            sif.in_valid = 1; sif.a = pix(0, p / IW, p % IW);
            #1 if (sif.in_ready) p++;
            guard++;
        end
        @(negedge clk);
        sif.in_valid = 0;
        rst = 1;
        @(negedge clk);
        #1 n_checks++;
        if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state ov=%b busy=%b want 0 0", sif.out_valid, busy);
        end
        rst = 0;
        repeat (3) @(negedge clk);
        #1 n_checks++;
        if (sif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_output ov=%b want 0", sif.out_valid);
        end
        run_frame("zero_coefs", 0, 0, 0, 0);
    endtask

    task automatic test_coef_ignored;
        load_coefs(0, 0);
        run_frame("run_write", 0, 1, 0, 1);
        run_frame("identity_again", 0, 1, 0, 0);
    endtask

    initial begin
        sif.a = '0; sif.in_valid = 0; sif.out_ready = 1;
        test_reset();
        test_identity();
        test_box();
        test_saturation();
        test_backpressure();
        test_reset_mid_frame();
        test_coef_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
